warp_issue_scheduler: RTL and testbench
=======================================

// Module: warp_issue_scheduler
// PURPOSE
//  Selects, each cycle, one warp whose decoded instruction is checked by the register
//  scoreboard. Drives the scoreboard's select-warp/packet-valid inputs and uses its
//  same-cycle ready result to issue. Pops the issued instruction from the per-warp
//  instruction buffer. Loose round-robin with a starvation lock so that no warp is
//  skipped indefinitely. Sits between the instruction buffer and the operand-read stage.
// PARAMETERS
//  NUM_WARP      8   number of warps (power of 2)
//  NUM_WARP_LOG  3   log2(NUM_WARP)
//  STARVE_LIMIT  15  failed ready checks of one warp before priority lock (1..2^CNT_W-1)
//  CNT_W         4   width of per-warp retry counter
// PORTS
//  clk           in   1             single clock; all state updates on rising edge
//  reset         in   1             synchronous, active-low (0 = reset)
//  stall_i       in   1             pipeline stall; freezes all scheduler state
//  ibufValid_i   in   NUM_WARP      warp w has a decoded instruction at buffer head
//  warpActive_i  in   NUM_WARP      warp w enabled (not finished, not at barrier)
//  sbReady_i     in   1             scoreboard ready for current candidate (same cycle)
//  candWarp_o    out  NUM_WARP_LOG  candidate warp -> scoreboard select-warp input
//  candValid_o   out  1             candidate valid -> scoreboard packet-valid input
//  ibufPop_o     out  NUM_WARP      one-hot pop of issued warp's buffer head
//  issueValid_o  out  1             registered: instruction issued last cycle
//  issueWarp_o   out  NUM_WARP_LOG  registered: warp issued last cycle
//  lockActive_o  out  1             FSM in LOCK state
//  issueCnt_o    out  32            issued-instruction count; wraps at 2^32
// BEHAVIOUR
//  - eligible[w] = ibufValid_i[w] & warpActive_i[w]. Regs: rrPtr, retryCnt[w], lockWarp, state.
//  - issue = candValid_o & sbReady_i & ~stall_i & reset; ibufPop_o = issue ? onehot(candWarp_o) : 0.
//  - SEARCH: candWarp_o = first eligible warp at/after rrPtr, wrapping NUM_WARP-1 -> 0;
//    candValid_o = |eligible; if none, candWarp_o = rrPtr.
//    On issue: rrPtr <= cand+1 (mod NUM_WARP); retryCnt[cand] <= 0.
//    On candValid_o & ~sbReady_i & ~stall_i: rrPtr <= cand+1; retryCnt[cand] += 1, saturating.
//    If the incremented value == STARVE_LIMIT: lockWarp <= cand, state <= LOCK.
//  - LOCK: candWarp_o = lockWarp; candValid_o = eligible[lockWarp]. rrPtr is held.
//    On issue: rrPtr <= lockWarp+1; retryCnt[lockWarp] <= 0; state <= SEARCH.
//    If ~eligible[lockWarp]: retryCnt[lockWarp] <= 0; state <= SEARCH next cycle (no issue).
//    ~sbReady_i in LOCK: stays in LOCK; counter stays saturated.
//  - stall_i=1: no update to rrPtr, retryCnt, state, lockWarp or issueCnt_o; ibufPop_o = 0;
//    issueValid_o <= 0. candWarp_o/candValid_o stay driven (scoreboard gates writes with stall).
//  - issueValid_o <= issue; issueWarp_o <= candWarp_o when issue, else holds. Latency: 1 cycle.
//  - issueCnt_o += 1 on each issue.
//  - Reset (reset=0 at edge): state=SEARCH, rrPtr=0, retryCnt=0, lockWarp=0, issueValid_o=0,
//    issueWarp_o=0, issueCnt_o=0, lockActive_o=0. While reset=0, candValid_o=0, ibufPop_o=0,
//    candWarp_o=0. A reset asserted in LOCK aborts the lock. Any pending candidate is dropped.
//  - Only one warp can be popped per cycle. A warp is never popped without sbReady_i in the
//    same cycle.
// TESTING
//  1 reset=0 2 cycles, all eligible, sbReady=1 -> candValid_o=0, ibufPop_o=0, issueValid_o=0, issueCnt_o=0
//  2 all 8 eligible, sbReady=1 -> pops 0,1,..,7,0 one per cycle; issueWarp_o trails by 1; issueCnt_o=9
//  3 eligible {1,5}, sbReady=0 when cand=1 -> cyc0 cand 1 no pop, cyc1 cand 5 pop 8'h20; retryCnt[1]=1
//  4 eligible {2,3}, sbReady=0 whenever cand=2 -> 15th fail sets lockActive_o=1, cand pinned 2;
//    sbReady=1 -> pop 8'h04, lock clears, next cand 3
//  5 stall_i=1 for 3 cycles with sbReady=1 -> no pops, issueValid_o=0, same cand resumes after stall
//  6 in LOCK on warp 4, drop ibufValid_i[4] -> SEARCH next cycle, retryCnt[4]=0, no pop of warp 4

Source files
------------

// File: rtl/warp_issue_scheduler.sv
// ---------------------------------------------------------------------------
// warp_issue_scheduler
//   Picks one warp per cycle and presents it to the register scoreboard. If the
//   scoreboard answers ready in the same cycle, the instruction issues and the
//   warp's instruction-buffer head is popped. Selection is a loose round-robin.
//   A per-warp retry counter tracks failed ready checks. When a warp hits the
//   starvation limit, the FSM locks onto that warp until it issues or drops out.
//
// Ports
//   clk, reset     : clock, synchronous active-low reset
//   stall_i        : freezes all scheduler state; suppresses pops
//   ibufValid_i    : per-warp decoded instruction available
//   warpActive_i   : per-warp enable
//   sbReady_i      : scoreboard verdict for the current candidate (same cycle)
//   candWarp_o     : candidate warp to the scoreboard
//   candValid_o    : candidate valid to the scoreboard
//   ibufPop_o      : one-hot pop of the issued warp
//   issueValid_o   : registered, an instruction issued last cycle
//   issueWarp_o    : registered, warp issued last cycle (holds otherwise)
//   lockActive_o   : FSM is in LOCK (debug view of the state)
//   issueCnt_o     : issued-instruction count, wraps at 2^32
//
// Handshake: the candidate is offered whenever candValid_o=1. A transfer
// (issue) happens in exactly those cycles where candValid_o & sbReady_i &
// ~stall_i hold. Both sides see the same-cycle result, with no buffering.
// ---------------------------------------------------------------------------
module warp_issue_scheduler #(
  parameter int NUM_WARP     = 8,
  parameter int NUM_WARP_LOG = 3,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic [NUM_WARP-1:0]     ibufValid_i,
  input  logic [NUM_WARP-1:0]     warpActive_i,
  input  logic                    sbReady_i,
  output logic [NUM_WARP_LOG-1:0] candWarp_o,
  output logic                    candValid_o,
  output logic [NUM_WARP-1:0]     ibufPop_o,
  output logic                    issueValid_o,
  output logic [NUM_WARP_LOG-1:0] issueWarp_o,
  output logic                    lockActive_o,
  output logic [31:0]             issueCnt_o
);

  typedef enum logic {S_SEARCH = 1'b0, S_LOCK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  state_t                  state_q;
  logic [NUM_WARP_LOG-1:0] rr_ptr_q;
  logic [CNT_W-1:0]        retry_q [NUM_WARP];
  logic [NUM_WARP_LOG-1:0] lock_warp_q;
  logic                    issue_valid_q;
  logic [NUM_WARP_LOG-1:0] issue_warp_q;
  logic [31:0]             issue_cnt_q;

  logic [NUM_WARP-1:0]     eligible;
  logic [NUM_WARP_LOG-1:0] search_warp;
  logic                    search_found;
  logic [NUM_WARP_LOG-1:0] scan_idx;
  logic [NUM_WARP_LOG-1:0] cand;
  logic                    cand_valid;
  logic                    issue;
  logic [CNT_W-1:0]        retry_inc;

  assign eligible = ibufValid_i & warpActive_i;

  // First eligible warp at or after rr_ptr_q. NUM_WARP is a power of two, so
  // the index wraps naturally in NUM_WARP_LOG bits.
  always_comb begin
    search_found = 1'b0;
    search_warp  = rr_ptr_q;
    scan_idx     = rr_ptr_q;
    for (int i = 0; i < NUM_WARP; i++) begin
      scan_idx = rr_ptr_q + NUM_WARP_LOG'(i);
      if (!search_found && eligible[scan_idx]) begin
        search_found = 1'b1;
        search_warp  = scan_idx;
      end
    end
  end

  // While in reset, nothing is offered, so any pending candidate is dropped.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    if (reset) begin
      if (state_q == S_LOCK) begin
        cand       = lock_warp_q;
        cand_valid = eligible[lock_warp_q];
      end else begin
        cand       = search_warp;
        cand_valid = search_found;
      end
    end
  end

  assign issue     = cand_valid & sbReady_i & ~stall_i;
  assign retry_inc = (retry_q[cand] == CNT_MAX) ? CNT_MAX : retry_q[cand] + CNT_W'(1);

  assign candWarp_o   = cand;
  assign candValid_o  = cand_valid;
  assign ibufPop_o    = issue ? (NUM_WARP'(1) << cand) : '0;
  assign issueValid_o = issue_valid_q;
  assign issueWarp_o  = issue_warp_q;
  assign lockActive_o = (state_q == S_LOCK);
  assign issueCnt_o   = issue_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_SEARCH;
      rr_ptr_q      <= '0;
      lock_warp_q   <= '0;
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_cnt_q   <= '0;
      for (int w = 0; w < NUM_WARP; w++) retry_q[w] <= '0;
    end else if (stall_i) begin
      issue_valid_q <= 1'b0;
    end else begin
      issue_valid_q <= issue;
      if (issue) begin
        issue_warp_q <= cand;
        issue_cnt_q  <= issue_cnt_q + 32'd1;
      end
      case (state_q)
        S_SEARCH: begin
          if (issue) begin
            rr_ptr_q      <= cand + NUM_WARP_LOG'(1);
            retry_q[cand] <= '0;
          end else if (cand_valid) begin
            rr_ptr_q      <= cand + NUM_WARP_LOG'(1);
            retry_q[cand] <= retry_inc;
            if (retry_inc == CNT_LIMIT) begin
              lock_warp_q <= cand;
              state_q     <= S_LOCK;
            end
          end
        end
        S_LOCK: begin
          // A refused ready keeps the lock and leaves the counter saturated.
          if (issue) begin
            rr_ptr_q             <= lock_warp_q + NUM_WARP_LOG'(1);
            retry_q[lock_warp_q] <= '0;
            state_q              <= S_SEARCH;
          end else if (!eligible[lock_warp_q]) begin
            retry_q[lock_warp_q] <= '0;
            state_q              <= S_SEARCH;
          end
        end
        default: state_q <= S_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
module tb_warp_issue_scheduler;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       stall_i;
  logic [7:0] ibufValid_i;
  logic [7:0] warpActive_i;
  logic       sbReady_i;
  logic [2:0] candWarp_o;
  logic       candValid_o;
  logic [7:0] ibufPop_o;
  logic       issueValid_o;
  logic [2:0] issueWarp_o;
  logic       lockActive_o;
  logic [31:0] issueCnt_o;

  always #5 clk = ~clk;

  warp_issue_scheduler #(
    .NUM_WARP(8), .NUM_WARP_LOG(3), .STARVE_LIMIT(15), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .ibufValid_i(ibufValid_i), .warpActive_i(warpActive_i), .sbReady_i(sbReady_i),
    .candWarp_o(candWarp_o), .candValid_o(candValid_o), .ibufPop_o(ibufPop_o),
    .issueValid_o(issueValid_o), .issueWarp_o(issueWarp_o),
    .lockActive_o(lockActive_o), .issueCnt_o(issueCnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scheduler rules at warp granularity: a pointer, a retry count per warp,
  // and an optional locked warp.
  int  m_rr;
  int  m_retry[8];
  bit  m_lock;
  int  m_lw;
  bit  m_iv;
  int  m_iw;
  int  m_cnt;
  int  m_cand;      // last modelled candidate, used for ready policy
  bit  m_issued;    // last modelled issue

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lw = 0; m_iv = 0; m_iw = 0; m_cnt = 0;
    foreach (m_retry[w]) m_retry[w] = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  // sbReady is rdy, except it is refused whenever the candidate equals deny.
  task automatic step(input bit rst, input bit stl, input logic [7:0] ibuf,
                      input logic [7:0] act, input bit rdy, input int deny);
    logic [7:0] elig;
    int  ec;
    bit  ev;
    bit  sb;
    bit  iss;
    bit  found;
    elig = ibuf & act;
    ec = 0; ev = 0; found = 0;
    if (rst) begin
      if (m_lock) begin
        ec = m_lw;
        ev = elig[m_lw];
      end else begin
        ec = m_rr;
        for (int k = 0; k < 8; k++) begin
          if (!found && elig[(m_rr + k) % 8]) begin
            found = 1;
            ec = (m_rr + k) % 8;
          end
        end
        ev = found;
      end
    end
    sb  = rdy && (ec != deny);
    iss = ev && sb && !stl && rst;

    reset = rst; stall_i = stl; ibufValid_i = ibuf; warpActive_i = act; sbReady_i = sb;
    #1;
    exp_q.push_back(32'(ec));
    exp_q.push_back(32'(ev));
    exp_q.push_back(iss ? (32'd1 << ec) : 32'd0);
    check_eq("cand_warp",   32'(candWarp_o),   exp_q.pop_front());
    check_eq("cand_valid",  32'(candValid_o),  exp_q.pop_front());
    check_eq("ibuf_pop",    32'(ibufPop_o),    exp_q.pop_front());
    check_eq("issue_valid", 32'(issueValid_o), 32'(m_iv));
    check_eq("issue_warp",  32'(issueWarp_o),  32'(m_iw));
    check_eq("issue_cnt",   issueCnt_o,        32'(m_cnt));
    check_eq("lock_active", 32'(lockActive_o), 32'(m_lock));

    m_cand = ec; m_issued = iss;
    if (!rst) begin
      model_reset();
    end else if (stl) begin
      m_iv = 0;
    end else begin
      m_iv = iss;
      if (iss) begin
        m_iw = ec;
        m_cnt++;
      end
      if (!m_lock) begin
        if (iss) begin
          m_rr = (ec + 1) % 8;
          m_retry[ec] = 0;
        end else if (ev) begin
          m_rr = (ec + 1) % 8;
          m_retry[ec] = (m_retry[ec] >= 15) ? 15 : m_retry[ec] + 1;
          if (m_retry[ec] == 15) begin
            m_lock = 1;
            m_lw = ec;
          end
        end
      end else begin
        if (iss) begin
          m_rr = (m_lw + 1) % 8;
          m_retry[m_lw] = 0;
          m_lock = 0;
        end else if (!elig[m_lw]) begin
          m_retry[m_lw] = 0;
          m_lock = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    m_cand = 0; m_issued = 0;
    reset = 0; stall_i = 0; ibufValid_i = '1; warpActive_i = '1; sbReady_i = 1;
    repeat (2) @(negedge clk);

    // reset held, everything eligible and ready: nothing offered or popped
    repeat (2) step(0, 0, 8'hFF, 8'hFF, 1, -1);

    // plain round-robin 0..7,0
    repeat (9) step(1, 0, 8'hFF, 8'hFF, 1, -1);
    check_eq("rr_issue_cnt", issueCnt_o, 32'd9);

    // {1,5}: warp 1 refused, warp 5 issues
    repeat (2) step(1, 0, 8'h22, 8'hFF, 1, 1);
    check_eq("retry_w1", 32'(m_retry[1]), 32'd1);
    check_eq("retry_w1_rr", 32'(issueWarp_o), 32'd5);

    // {2,3}: warp 2 always refused until it locks
    for (int c = 0; c < 60 && !m_lock; c++) step(1, 0, 8'h0C, 8'hFF, 1, 2);
    check_eq("lock_reached", 32'(lockActive_o), 32'd1);
    repeat (3) step(1, 0, 8'h0C, 8'hFF, 1, 2);
    step(1, 0, 8'h0C, 8'hFF, 1, -1);          // pop 8'h04, lock clears
    step(1, 0, 8'h0C, 8'hFF, 1, -1);          // next candidate 3
    check_eq("post_lock_warp", 32'(issueWarp_o), 32'd3);

    // stall for 3 cycles, then resume with the same candidate
    repeat (3) step(1, 1, 8'hFF, 8'hFF, 1, -1);
    repeat (2) step(1, 0, 8'hFF, 8'hFF, 1, -1);

    // lock on warp 4, then drop its buffer-valid
    for (int c = 0; c < 40 && !m_lock; c++) step(1, 0, 8'h10, 8'hFF, 1, 4);
    check_eq("lock_w4", 32'(candWarp_o), 32'd4);
    repeat (2) step(1, 0, 8'h10, 8'hFF, 1, 4);
    step(1, 0, 8'h40, 8'hFF, 1, 4);           // warp 4 gone: back to SEARCH
    check_eq("unlock_retry_w4", 32'(m_retry[4]), 32'd0);
    repeat (14) step(1, 0, 8'h50, 8'hFF, 1, 4); // counter restarted: no relock yet
    check_eq("no_relock", 32'(lockActive_o), 32'd0);

    // reset while locked aborts the lock
    for (int c = 0; c < 40 && !m_lock; c++) step(1, 0, 8'h50, 8'hFF, 1, 4);
    step(0, 0, 8'h50, 8'hFF, 1, -1);
    step(1, 0, 8'h50, 8'hFF, 1, -1);

    // randomized traffic
    begin
      int deny;
      deny = -1;
      for (int c = 0; c < 600; c++) begin
        if (c % 50 == 0) deny = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7));
        step($urandom_range(0, 49) != 0,
             $urandom_range(0, 9) == 0,
             8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
             $urandom_range(0, 3) != 0,
             deny);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
